// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multiply/divide unit.
// State encoding, iteration count and the ALU-op codes decoded to ctrl_*.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam int MD_ITER = 32;

  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;

endpackage

// File: rtl/multdiv_unit_div_core.sv
// div_core: restoring divider on unsigned magnitudes, one quotient bit per step.
// Ports: clock, load (capture operands), step (advance one bit), dividend,
// divisor, quo_nxt (quotient after the current step). Built with MULTDIV_DIV_EN.
`ifdef MULTDIV_DIV_EN
module div_core
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // rem < dvs always holds, so a successful subtract fits in WIDTH bits
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    fits    = shifted >= {1'b0, dvs};
    rem_nxt = fits ? shifted[WIDTH-1:0] - dvs
                   : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clock) begin
    if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule
`endif

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed multiply (Booth) / divide for the X stage.
// Ports: clock, reset, ctrl_mult, ctrl_div, data_a, data_b -> result,
// data_exception, ready (1-cycle pulse), stall. Divider needs MULTDIV_DIV_EN.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MD_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic             data_exception,
  output logic             ready,
  output logic             stall
);

  localparam int CW = $clog2(ITER + 1);
  localparam int PW = 2 * WIDTH + 1;

  md_state_e        state;
  md_state_e        state_nxt;
  logic [CW-1:0]    cnt;
  logic             go;
  logic             start_div;
  logic             last;
  logic             div_zero;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   addend;
  logic [WIDTH-1:0] mul_res;
  logic             mul_ovf;
  logic [WIDTH-1:0] fin_res;
  logic             fin_exc;

  assign go        = ctrl_mult | ctrl_div;
  assign start_div = ctrl_div & ~ctrl_mult;
  assign last      = (cnt == CW'(ITER - 1));

  // Booth step; the add is one bit wider so the shifted-in sign is exact
  always_comb begin
    addend = {mcand[WIDTH-1], mcand};
    acc    = {prod[PW-1], prod[PW-1:WIDTH+1]};
    unique case (prod[1:0])
      2'b01:   acc = acc + addend;
      2'b10:   acc = acc - addend;
      default: acc = acc;
    endcase
    prod_nxt = {acc, prod[WIDTH:1]};
  end

  // product bits [63:31] must be all-equal for the low word to be exact
  assign mul_res = prod_nxt[WIDTH:1];
  assign mul_ovf = ~((&prod_nxt[PW-1:WIDTH]) |
                     ~(|prod_nxt[PW-1:WIDTH]));

`ifdef MULTDIV_DIV_EN
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] div_res;
  logic             op_div;
  logic             neg_q;
  logic             div_ovf;

  assign a_mag    = data_a[WIDTH-1] ? -data_a : data_a;
  assign b_mag    = data_b[WIDTH-1] ? -data_b : data_b;
  assign div_zero = (data_b == '0);
  assign div_res  = neg_q ? -quo_nxt : quo_nxt;

  div_core #(.WIDTH(WIDTH)) u_div (
    .clock    (clock),
    .load     ((state == IDLE) & start_div),
    .step     ((state == RUN) & op_div),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_nxt  (quo_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      op_div  <= 1'b0;
      neg_q   <= 1'b0;
      div_ovf <= 1'b0;
    end else if ((state == IDLE) && go) begin
      op_div  <= start_div;
      neg_q   <= data_a[WIDTH-1] ^ data_b[WIDTH-1];
      div_ovf <= (data_a == {1'b1, {(WIDTH-1){1'b0}}})
               & (&data_b);
    end
  end

  always_comb begin
    fin_res = mul_res;
    fin_exc = mul_ovf;
    if (op_div) begin
      fin_res = div_res;
      fin_exc = div_ovf;
    end
  end
`else
  // no divider: every lone divide traps straight away
  assign div_zero = 1'b1;

  always_comb begin
    fin_res = mul_res;
    fin_exc = mul_ovf;
  end
`endif

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          stall = 1'b1;
          if (start_div && div_zero)
            state_nxt = DONE;
          else
            state_nxt = RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (last)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      result         <= '0;
      data_exception <= 1'b0;
      ready          <= 1'b0;
      prod           <= '0;
      mcand          <= '0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == DONE);
      unique case (state)
        IDLE: begin
          if (go) begin
            cnt   <= '0;
            prod  <= {{WIDTH{1'b0}}, data_b, 1'b0};
            mcand <= data_a;
            if (state_nxt == DONE) begin
              result         <= '0;
              data_exception <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt  <= cnt + CW'(1);
          prod <= prod_nxt;
          if (last) begin
            result         <= fin_res;
            data_exception <= fin_exc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit.
// Driver queues expected responses; a monitor pops them on each ready pulse.
module tb_multdiv_unit;

`ifdef MULTDIV_DIV_EN
  localparam bit DIV_HW = 1'b1;
`else
  localparam bit DIV_HW = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          stl;
    string       nm;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] result;
  logic        data_exception;
  logic        ready;
  logic        stall;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;
  int   stall_cnt;
  bit   prev_ready;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .data_a         (data_a),
    .data_b         (data_b),
    .result         (result),
    .data_exception (data_exception),
    .ready          (ready),
    .stall          (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    if (reset) begin
      stall_cnt = 0;
    end else begin
      if (stall) stall_cnt++;
      if (ready) begin
        chk("ready_pulse", 32'(prev_ready), 32'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ready: got result %h want none",
                   result);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_res"}, result, e.res);
          chk({e.nm, "_exc"}, 32'(data_exception), 32'(e.exc));
          chk({e.nm, "_stall"}, 32'(stall_cnt), 32'(e.stl));
        end
        stall_cnt = 0;
      end
    end
    prev_ready = ready;
  endtask

  task automatic wait_ready(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no ready want ready", nm);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic run_op(input string nm,
                        input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit exc,
                        input int stl, input bit inject);
    exp_t e;
    e.res = res;
    e.exc = exc;
    e.stl = stl;
    e.nm  = nm;
    sb.push_back(e);
    @(posedge clock);
    #1;
    ctrl_mult = m;
    ctrl_div  = d;
    data_a    = a;
    data_b    = b;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    if (inject) begin
      repeat (4) @(posedge clock);
      #1;
      ctrl_div = 1'b1;
      data_a   = 32'd100;
      data_b   = 32'd7;
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
    end
    wait_ready(nm);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    stall_cnt  = 0;
    prev_ready = 1'b0;
    reset      = 1'b1;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    data_a     = '0;
    data_b     = '0;

    fork
      forever begin
        @(negedge clock);
        mon_step();
      end
    join_none

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_result", result, 32'd0);
    chk("rst_exc", 32'(data_exception), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFFFFFD,
           32'hFFFFFFEB, 0, 33, 0);
    run_op("mul_ovf", 1, 0, 32'h00010000, 32'h00010000,
           32'h00000000, 1, 33, 0);
    run_op("mul_min_m1", 1, 0, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 1, 33, 0);
    run_op("mul_min_1", 1, 0, 32'h80000000, 32'd1,
           32'h80000000, 0, 33, 0);
    run_op("mul_max_2", 1, 0, 32'h7FFFFFFF, 32'd2,
           32'hFFFFFFFE, 1, 33, 0);
    run_op("mul_min_min", 1, 0, 32'h80000000, 32'h80000000,
           32'h00000000, 1, 33, 0);
    run_op("mul_m1_m1", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'd1, 0, 33, 0);

    run_op("div_m21_4", 0, 1, 32'hFFFFFFEB, 32'd4,
           DIV_HW ? 32'hFFFFFFFB : 32'd0, !DIV_HW,
           DIV_HW ? 33 : 1, 0);
    run_op("div_min_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF,
           DIV_HW ? 32'h80000000 : 32'd0, 1,
           DIV_HW ? 33 : 1, 0);
    run_op("div_5_0", 0, 1, 32'd5, 32'd0,
           32'd0, 1, 1, 0);
    run_op("div_5_1", 0, 1, 32'd5, 32'd1,
           DIV_HW ? 32'd5 : 32'd0, !DIV_HW,
           DIV_HW ? 33 : 1, 0);
    run_op("div_7_m2", 0, 1, 32'd7, 32'hFFFFFFFE,
           DIV_HW ? 32'hFFFFFFFD : 32'd0, !DIV_HW,
           DIV_HW ? 33 : 1, 0);

    // abort a multiply with reset at E10
    @(posedge clock);
    #1;
    ctrl_mult = 1'b1;
    data_a    = 32'd5;
    data_b    = 32'd5;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_result", result, 32'd0);
    chk("abort_exc", 32'(data_exception), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    repeat (40) @(negedge clock);

    run_op("mul_3_4", 1, 0, 32'd3, 32'd4,
           32'd12, 0, 33, 0);
    run_op("mul_6_7_inj", 1, 0, 32'd6, 32'd7,
           32'd42, 0, 33, 1);
    run_op("mul_div_both", 1, 1, 32'd2, 32'd3,
           32'd6, 0, 33, 0);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
